// File: rtl/tlast_join.sv
// tlast_join: pairs a buffered data-beat stream with a buffered per-beat
// last-flag stream and emits an AXI-Stream beat with TLAST through a
// registered output stage.
module tlast_join #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned LAST_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] i_data,
  input  logic                 i_data_valid,
  output logic                 o_data_ready,
  input  logic                 i_last,
  input  logic                 i_last_valid,
  output logic [BUS_WIDTH-1:0] o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 i_tready,
  output logic                 o_last_overflow,
  output logic [15:0]          o_pkt_count
);

  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned LAW = $clog2(LAST_DEPTH);
  localparam int unsigned DCW = DAW + 1;
  localparam int unsigned LCW = LAW + 1;

  // Data FIFO storage and bookkeeping
  logic [BUS_WIDTH-1:0] data_mem [DATA_DEPTH];
  logic [DAW-1:0]       data_wr;
  logic [DAW-1:0]       data_rd;
  logic [DCW-1:0]       data_count;
  logic [DCW-1:0]       data_count_next;

  // Flag FIFO storage and bookkeeping
  logic [LAST_DEPTH-1:0] last_mem;
  logic [LAW-1:0]        last_wr;
  logic [LAW-1:0]        last_rd;
  logic [LCW-1:0]        last_count;

  logic data_empty;
  logic last_full;
  logic last_empty;
  logic data_push;
  logic last_push;
  logic last_drop;
  logic load;

  // FIFO status, push/pop qualification and next data occupancy
  always_comb begin
    data_empty      = 1'b0;
    last_full       = 1'b0;
    last_empty      = 1'b0;
    data_push       = 1'b0;
    last_push       = 1'b0;
    last_drop       = 1'b0;
    load            = 1'b0;
    data_count_next = data_count;

    data_empty = (data_count == DCW'(0));
    last_full  = (last_count == LCW'(LAST_DEPTH));
    last_empty = (last_count == LCW'(0));

    // o_data_ready mirrors !full of the registered count, so no push while full
    data_push  = i_data_valid && o_data_ready;
    load       = !data_empty && !last_empty && (!o_tvalid || i_tready);
    // A full flag FIFO still accepts a flag when a pop frees a slot this cycle
    last_push  = i_last_valid && (!last_full || load);
    last_drop  = i_last_valid && last_full && !load;

    if (data_push && !load) begin
      data_count_next = data_count + DCW'(1);
    end else if (load && !data_push) begin
      data_count_next = data_count - DCW'(1);
    end
  end

  // Data FIFO write port; contents need no reset since pointers are cleared
  always_ff @(posedge clk) begin
    if (data_push) begin
      data_mem[data_wr] <= i_data;
    end
  end

  // Flag FIFO write port
  always_ff @(posedge clk) begin
    if (last_push) begin
      last_mem[last_wr] <= i_last;
    end
  end

  // Pointers, occupancy, ready and overflow state
  always_ff @(posedge clk) begin
    if (reset) begin
      data_wr         <= '0;
      data_rd         <= '0;
      data_count      <= '0;
      o_data_ready    <= 1'b1;
      last_wr         <= '0;
      last_rd         <= '0;
      last_count      <= '0;
      o_last_overflow <= 1'b0;
    end else begin
      if (data_push) begin
        data_wr <= data_wr + DAW'(1);
      end
      if (load) begin
        data_rd <= data_rd + DAW'(1);
        last_rd <= last_rd + LAW'(1);
      end
      data_count   <= data_count_next;
      o_data_ready <= (data_count_next != DCW'(DATA_DEPTH));

      if (last_push) begin
        last_wr <= last_wr + LAW'(1);
      end
      if (last_push && !load) begin
        last_count <= last_count + LCW'(1);
      end else if (load && !last_push) begin
        last_count <= last_count - LCW'(1);
      end

      if (last_drop) begin
        o_last_overflow <= 1'b1;
      end
    end
  end

  // Output register: holds under backpressure, reloads on the handshake cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
    end else if (load) begin
      o_tvalid <= 1'b1;
      o_tdata  <= data_mem[data_rd];
      o_tlast  <= last_mem[last_rd];
    end else if (i_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  // Completed-packet counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      o_pkt_count <= '0;
    end else if (o_tvalid && i_tready && o_tlast) begin
      o_pkt_count <= o_pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tlast_join.sv
// tb_tlast_join: directed checks of beat/flag pairing, latency, backpressure,
// FIFO full/overflow behaviour and reset for tlast_join.
module tb_tlast_join;

  logic        clk;
  logic        reset;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic        i_last;
  logic        i_last_valid;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        i_tready;
  logic        o_last_overflow;
  logic [15:0] o_pkt_count;

  int total;
  int bad;

  tlast_join #(
    .BUS_WIDTH (32),
    .DATA_DEPTH(16),
    .LAST_DEPTH(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_data         (i_data),
    .i_data_valid   (i_data_valid),
    .o_data_ready   (o_data_ready),
    .i_last         (i_last),
    .i_last_valid   (i_last_valid),
    .o_tdata        (o_tdata),
    .o_tlast        (o_tlast),
    .o_tvalid       (o_tvalid),
    .i_tready       (i_tready),
    .o_last_overflow(o_last_overflow),
    .o_pkt_count    (o_pkt_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    int acc;
    int idx;
    int k;
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_last       = 1'b0;
    i_last_valid = 1'b0;
    i_tready     = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tdata", o_tdata, 32'd0);
    check("rst_tlast", 32'(o_tlast), 32'd0);
    check("rst_ovf", 32'(o_last_overflow), 32'd0);
    check("rst_pkt", 32'(o_pkt_count), 32'd0);
    reset = 1'b0;
    check("rst_ready", 32'(o_data_ready), 32'd1);

    // Single packet: beats cycles 0-3, flags cycles 1-4
    i_data_valid = 1'b1; i_data = 32'hA0;
    tick();
    i_data = 32'hA1; i_last_valid = 1'b1; i_last = 1'b0;
    tick();
    i_data = 32'hA2;
    tick();
    i_data = 32'hA3;
    check("p1_v0", 32'(o_tvalid), 32'd1);
    check("p1_d0", o_tdata, 32'hA0);
    check("p1_l0", 32'(o_tlast), 32'd0);
    tick();
    i_data_valid = 1'b0; i_last = 1'b1;
    check("p1_d1", o_tdata, 32'hA1);
    check("p1_l1", 32'(o_tlast), 32'd0);
    tick();
    i_last_valid = 1'b0;
    check("p1_d2", o_tdata, 32'hA2);
    check("p1_l2", 32'(o_tlast), 32'd0);
    tick();
    check("p1_v3", 32'(o_tvalid), 32'd1);
    check("p1_d3", o_tdata, 32'hA3);
    check("p1_l3", 32'(o_tlast), 32'd1);
    check("p1_pkt_pre", 32'(o_pkt_count), 32'd0);
    tick();
    check("p1_idle", 32'(o_tvalid), 32'd0);
    check("p1_pkt", 32'(o_pkt_count), 32'd1);

    // Flags ahead of data
    i_last_valid = 1'b1; i_last = 1'b0;
    tick();
    tick();
    i_last = 1'b1;
    tick();
    i_last_valid = 1'b0;
    tick();
    tick();
    check("fa_nodata", 32'(o_tvalid), 32'd0);
    i_data_valid = 1'b1; i_data = 32'hB00;
    tick();
    i_data = 32'hB01;
    tick();
    i_data = 32'hB02;
    check("fa_v0", 32'(o_tvalid), 32'd1);
    check("fa_d0", o_tdata, 32'hB00);
    check("fa_l0", 32'(o_tlast), 32'd0);
    tick();
    i_data_valid = 1'b0;
    check("fa_d1", o_tdata, 32'hB01);
    check("fa_l1", 32'(o_tlast), 32'd0);
    tick();
    check("fa_d2", o_tdata, 32'hB02);
    check("fa_l2", 32'(o_tlast), 32'd1);
    tick();
    check("fa_idle", 32'(o_tvalid), 32'd0);
    check("fa_pkt", 32'(o_pkt_count), 32'd2);
    check("fa_ovf", 32'(o_last_overflow), 32'd0);

    // Backpressure: two 3-beat packets, tready pattern 1,0,0 repeating
    i_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_data_valid = 1'b1; i_data = 32'hC00 + 32'(i);
      i_last_valid = 1'b1; i_last = (i == 2 || i == 5);
      tick();
    end
    i_data_valid = 1'b0; i_last_valid = 1'b0;
    idx = 0;
    k   = 0;
    while (idx < 6 && k < 40) begin
      i_tready = (k % 3 == 0);
      check("bp_v", 32'(o_tvalid), 32'd1);
      check("bp_d", o_tdata, 32'hC00 + 32'(idx));
      check("bp_l", 32'(o_tlast), (idx == 2 || idx == 5) ? 32'd1 : 32'd0);
      tick();
      if (i_tready) idx++;
      k++;
    end
    i_tready = 1'b0;
    check("bp_done", 32'(idx), 32'd6);
    check("bp_idle", 32'(o_tvalid), 32'd0);
    check("bp_pkt", 32'(o_pkt_count), 32'd4);

    // Data FIFO full with output stalled and no flags
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      i_data_valid = 1'b1; i_data = 32'hD00 + 32'(i);
      if (o_data_ready) acc++;
      tick();
    end
    i_data_valid = 1'b0;
    check("df_acc", 32'(acc), 32'd16);
    check("df_rdy0", 32'(o_data_ready), 32'd0);
    i_last_valid = 1'b1; i_last = 1'b1;
    tick();
    i_last_valid = 1'b0;
    check("df_rdy1", 32'(o_data_ready), 32'd0);
    check("df_v0", 32'(o_tvalid), 32'd0);
    tick();
    check("df_rdy2", 32'(o_data_ready), 32'd1);
    check("df_v1", 32'(o_tvalid), 32'd1);
    check("df_d", o_tdata, 32'hD00);
    check("df_l", 32'(o_tlast), 32'd1);
    i_tready = 1'b1;
    tick();
    check("df_pkt", 32'(o_pkt_count), 32'd5);
    check("df_idle", 32'(o_tvalid), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("df_rst_v", 32'(o_tvalid), 32'd0);
    check("df_rst_pkt", 32'(o_pkt_count), 32'd0);
    check("df_rst_rdy", 32'(o_data_ready), 32'd1);

    // Flag FIFO fill, simultaneous push/pop while full, then overflow
    for (int i = 0; i < 16; i++) begin
      i_last_valid = 1'b1; i_last = 1'b0;
      tick();
    end
    i_last_valid = 1'b0;
    check("ov_fill", 32'(o_last_overflow), 32'd0);
    i_data_valid = 1'b1; i_data = 32'hE00;
    tick();
    i_data_valid = 1'b0;
    i_last_valid = 1'b1; i_last = 1'b1;
    tick();
    check("ov_simul", 32'(o_last_overflow), 32'd0);
    check("ov_v", 32'(o_tvalid), 32'd1);
    check("ov_d", o_tdata, 32'hE00);
    check("ov_l", 32'(o_tlast), 32'd0);
    i_last = 1'b0;
    tick();
    i_last_valid = 1'b0;
    check("ov_set", 32'(o_last_overflow), 32'd1);
    check("ov_idle", 32'(o_tvalid), 32'd0);
    for (int j = 0; j <= 16; j++) begin
      if (j < 16) begin
        i_data_valid = 1'b1; i_data = 32'hE01 + 32'(j);
      end else begin
        i_data_valid = 1'b0;
      end
      tick();
      if (j >= 1) begin
        check("ov_sv", 32'(o_tvalid), 32'd1);
        check("ov_sd", o_tdata, 32'hE00 + 32'(j));
        check("ov_sl", 32'(o_tlast), (j == 16) ? 32'd1 : 32'd0);
      end
    end
    tick();
    check("ov_pkt", 32'(o_pkt_count), 32'd1);
    check("ov_end", 32'(o_tvalid), 32'd0);
    check("ov_sticky", 32'(o_last_overflow), 32'd1);

    // Reset mid-packet: 2 beats + 1 flag buffered, output valid
    i_tready = 1'b0;
    i_data_valid = 1'b1; i_data = 32'hF00; i_last_valid = 1'b1; i_last = 1'b0;
    tick();
    i_data = 32'hF01; i_last = 1'b1;
    tick();
    i_data = 32'hF02; i_last_valid = 1'b0;
    tick();
    i_data_valid = 1'b0;
    check("rm_v", 32'(o_tvalid), 32'd1);
    check("rm_d", o_tdata, 32'hF00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm_tvalid", 32'(o_tvalid), 32'd0);
    check("rm_tdata", o_tdata, 32'd0);
    check("rm_tlast", 32'(o_tlast), 32'd0);
    check("rm_ovf", 32'(o_last_overflow), 32'd0);
    check("rm_pkt", 32'(o_pkt_count), 32'd0);
    check("rm_rdy", 32'(o_data_ready), 32'd1);
    i_tready = 1'b1;
    i_data_valid = 1'b1; i_data = 32'h1234; i_last_valid = 1'b1; i_last = 1'b1;
    tick();
    i_data_valid = 1'b0; i_last_valid = 1'b0;
    tick();
    check("rm_nv", 32'(o_tvalid), 32'd1);
    check("rm_nd", o_tdata, 32'h1234);
    check("rm_nl", 32'(o_tlast), 32'd1);
    tick();
    check("rm_npkt", 32'(o_pkt_count), 32'd1);
    check("rm_nidle", 32'(o_tvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
